serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands using one external two_bit_adder slice, two bits per cycle, LSB pair first. It latches the operands on start and drives the slice inputs each cycle. Between steps it keeps the ripple carry in a register, then presents the registered sum and carry-out with a one-cycle done pulse. It sits between the user I/O / top-level control and the two_bit_adder instance, so a narrow adder can serve wide operands.

Parameters:
WIDTH, 8, operand and sum width in bits; must be even and >= 2 (elaboration error otherwise)
STEPS, WIDTH/2, derived (localparam): number of slice additions per operation

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op_a  in  WIDTH  operand A, captured on accepted start
op_b  in  WIDTH  operand B, captured on accepted start
cin_init  in  1  initial carry-in, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when sum/cout are valid
sum  out  WIDTH  registered result, held until next accepted start
cout  out  1  registered final carry, held with sum
slice_a  out  2  to two_bit_adder a
slice_b  out  2  to two_bit_adder b
slice_cin  out  1  to two_bit_adder cin
slice_s  in  2  from two_bit_adder s
slice_cout  in  1  from two_bit_adder cout

Behaviour:
- Reset (rst_n low, async): state IDLE; busy=0, done=0, sum=0, cout=0, slice_a/b/cin=0; internal shift regs, carry and step counter cleared. Takes effect immediately, including mid-RUN. The in-flight operation is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1 at a rising edge, latch op_a/op_b into A/B shift regs, cin_init into the carry reg, and clear step to 0; go to RUN. Otherwise stay in IDLE.
- RUN: slice_a=A[1:0], slice_b=B[1:0], slice_cin=carry (combinational from registers). Each edge:
  - shift slice_s into the top of the accumulator (acc <= {slice_s, acc[WIDTH-1:2]});
  - carry <= slice_cout;
  - A, B shift right by 2;
  - step++.
- RUN exit: on the edge where step==STEPS-1, also load sum <= {slice_s, acc[WIDTH-1:2]} and cout <= slice_cout, and go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE on the next edge unconditionally.
- start is ignored in RUN and DONE; no queuing.
- Latency: start sampled at edge E0; done is high from edge E0+STEPS to E0+STEPS+1. sum/cout are valid from E0+STEPS. Back-to-back throughput is one operation per STEPS+2 cycles.
- Outputs outside RUN: slice_a/b/cin are 0 in IDLE and DONE.
- busy: busy=1 exactly in RUN.
- sum/cout during a new operation: they keep the previous result until the new operation's final edge.
- Operand changes: op_a/op_b/cin_init may change freely after the accepting edge with no effect.
- Arithmetic: {cout,sum} == op_a + op_b + cin_init, modulo 2^(WIDTH+1).

Test Plan:
- WIDTH=8, op_a=0x00, op_b=0x00, cin_init=0, start 1 cycle -> busy for 4 cycles; done pulse 4 cycles after start edge; sum=0x00, cout=0.
- WIDTH=8, 0x3C + 0x0F, cin 0 -> slice_(a,b,cin) sequence (00,11,0),(11,11,0),(11,00,1),(00,00,1); result sum=0x4B, cout=0.
- WIDTH=8, 0xFF + 0x01, cin 0 -> sum=0x00, cout=1. Then 0xA5 + 0x5A, cin 1 -> sum=0x00, cout=1; previous sum held until the final edge.
- start held high through RUN/DONE -> exactly one operation per IDLE acceptance. A second start while busy with 0x11+0x22 does not alter the result of the first operation.
- rst_n pulled low after 2 RUN edges -> outputs 0 immediately, no done pulse. Next start 0x01+0x01 -> sum=0x02, cout=0.
- WIDTH=4, exhaustive sweep of all op_a, op_b, cin_init (512 cases) against the reference model {cout,sum}=a+b+cin. Also check done timing each case.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Sequences a WIDTH-bit add through one external two_bit_adder slice, LSB pair first.
// Latency: done pulses STEPS cycles after the accepting edge; one op per STEPS+2 cycles.
// Backpressure: start is accepted only in IDLE; requests during RUN/DONE are dropped.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_s,
    input  logic             slice_cout
);

    localparam int STEPS = WIDTH / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_sr, b_sr, acc, acc_nxt;
    logic              carry;
    logic [SW-1:0]     step;
    logic              last_step;

    // New slice result enters at the top so the LSB pair ends up at bit 0.
    if (WIDTH == 2) begin : g_acc_narrow
        assign acc_nxt = slice_s;
    end else begin : g_acc_wide
        assign acc_nxt = {slice_s, acc[WIDTH-1:2]};
    end

    assign last_step = (step == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        slice_a   = 2'b00;
        slice_b   = 2'b00;
        slice_cin = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                slice_a   = a_sr[1:0];
                slice_b   = b_sr[1:0];
                slice_cin = carry;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            step  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_sr  <= op_a;
                b_sr  <= op_b;
                carry <= cin_init;
                step  <= '0;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                carry <= slice_cout;
                a_sr  <= a_sr >> 2;
                b_sr  <= b_sr >> 2;
                step  <= step + 1'b1;
                // sum/cout keep the previous result until this final edge.
                if (last_step) begin
                    sum  <= acc_nxt;
                    cout <= slice_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed cases and WIDTH=4 exhaustive sweep,
// each instance driving its own behavioural two_bit_adder.
module tb_serial_adder_ctrl;

    logic core_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // WIDTH=8 instance
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] op_a8 = '0, op_b8 = '0, sum8;
    logic       busy8, done8, cout8;
    logic [1:0] sa8, sb8, ss8;
    logic       sc8, sco8;
    assign {sco8, ss8} = {1'b0, sa8} + {1'b0, sb8} + {2'b00, sc8};

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(core_clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .cin_init(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_s(ss8), .slice_cout(sco8)
    );

    // WIDTH=4 instance
    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] op_a4 = '0, op_b4 = '0, sum4;
    logic       busy4, done4, cout4;
    logic [1:0] sa4, sb4, ss4;
    logic       sc4, sco4;
    assign {sco4, ss4} = {1'b0, sa4} + {1'b0, sb4} + {2'b00, sc4};

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(core_clk), .rst_n(rst_n), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .cin_init(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .slice_a(sa4), .slice_b(sb4), .slice_cin(sc4), .slice_s(ss4), .slice_cout(sco4)
    );

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] held8 = '0;
    logic [1:0] rec_a[4], rec_b[4];
    logic       rec_c[4];

    // Scoreboards: every done pulse must match the oldest outstanding expectation.
    always @(negedge core_clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) chk("sb8_unexpected_done", 1, 0);
            else chk("sb8_result", {cout8, sum8}, q8.pop_front());
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) chk("sb4_unexpected_done", 1, 0);
            else chk("sb4_result", {cout4, sum4}, q4.pop_front());
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat, nb;
        logic [8:0] e;
        e = {1'b0, a} + {1'b0, b} + {8'b0, c};
        q8.push_back(e);
        @(negedge core_clk);
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge core_clk); #1;
        start8 = 1'b0;
        op_a8 = 8'($urandom); op_b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0; nb = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            if (busy8 === 1'b1) begin
                if (nb < 4) begin
                    rec_a[nb] = sa8; rec_b[nb] = sb8; rec_c[nb] = sc8;
                end
                nb++;
                chk("sum8_held", {cout8, sum8}, held8);
            end
            @(posedge core_clk); #1;
            lat++;
        end
        chk("lat8", lat, 4);
        chk("busy_cycles8", nb, 4);
        chk("idle_slices8_done", {sa8, sb8, sc8}, 0);
        held8 = e;
        @(posedge core_clk); #1;
        chk("done8_one_cycle", done8, 0);
        chk("busy8_after", busy8, 0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int lat;
        q4.push_back({1'b0, a} + {1'b0, b} + {4'b0, c});
        @(negedge core_clk);
        op_a4 = a; op_b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge core_clk); #1;
        start4 = 1'b0;
        op_a4 = 4'($urandom); op_b4 = 4'($urandom);
        lat = 0;
        while (done4 !== 1'b1 && lat < 10) begin
            @(posedge core_clk); #1;
            lat++;
        end
        chk("lat4", lat, 2);
        @(posedge core_clk); #1;
    endtask

    initial begin
        int ndone;
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum_cout", {cout8, sum8}, 0);
        chk("rst_slices", {sa8, sb8, sc8}, 0);
        @(negedge core_clk);
        rst_n = 1'b1;

        run8(8'h00, 8'h00, 1'b0);

        run8(8'h3C, 8'h0F, 1'b0);
        chk("slice0", {rec_a[0], rec_b[0], rec_c[0]}, {2'b00, 2'b11, 1'b0});
        chk("slice1", {rec_a[1], rec_b[1], rec_c[1]}, {2'b11, 2'b11, 1'b0});
        chk("slice2", {rec_a[2], rec_b[2], rec_c[2]}, {2'b11, 2'b00, 1'b1});
        chk("slice3", {rec_a[3], rec_b[3], rec_c[3]}, {2'b00, 2'b00, 1'b1});

        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1);
        run8(8'h80, 8'h7F, 1'b0);

        // start held high: first op uses 0x11+0x22, the re-acceptance in IDLE uses 0x77+0x66.
        q8.push_back(9'h033);
        q8.push_back(9'h0DD);
        @(negedge core_clk);
        op_a8 = 8'h11; op_b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        @(posedge core_clk); #1;
        op_a8 = 8'h77; op_b8 = 8'h66;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge core_clk); #1;
            if (done8 === 1'b1) ndone++;
            if (i == 5) start8 = 1'b0;
        end
        chk("held_start_ops", ndone, 2);
        held8 = 9'h0DD;

        // Reset mid-RUN: the operation is discarded without a done pulse.
        @(negedge core_clk);
        op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge core_clk); #1;
        start8 = 1'b0;
        @(posedge core_clk);
        @(posedge core_clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        chk("arst_sum_cout", {cout8, sum8}, 0);
        chk("arst_slices", {sa8, sb8, sc8}, 0);
        @(negedge core_clk);
        rst_n = 1'b1;
        held8 = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge core_clk); #1;
            chk("no_done_after_rst", done8, 0);
        end
        run8(8'h01, 8'h01, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run4(4'(a), 4'(b), 1'(c));

        repeat (4) @(posedge core_clk);
        #1;
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
